// File: rtl/maze_pkg.sv
// Shared MAZE definitions: packet layout, link counts and the cyclic
// find-first-set used by the ejection arbiter.
package maze_pkg;

  localparam int PKT_W    = 23;
  localparam int TYPE_MSB = 22;
  localparam int TYPE_LSB = 21;
  localparam int QOS_BIT  = 20;
  localparam int SRC_MSB  = 19;
  localparam int SRC_LSB  = 14;
  localparam int TGT_MSB  = 13;
  localparam int TGT_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam int N_X_LINKS = 7;
  localparam int N_Y_LINKS = 7;

  // Widest requester vector rr_pick handles; smaller users zero-extend.
  localparam int RR_MAX   = 16;
  localparam int RR_IDX_W = 4;

  typedef struct packed {
    logic [TYPE_MSB-TYPE_LSB:0] ptype;
    logic                       qos;
    logic [SRC_MSB-SRC_LSB:0]   src;
    logic [TGT_MSB-TGT_LSB:0]   tgt;
    logic [DATA_MSB-DATA_LSB:0] data;
  } pkt_t;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_res_t;

  // First set bit of req at or after ptr, cyclic over 0..n-1 (ptr < n <= RR_MAX).
  function automatic rr_res_t rr_pick(input logic [RR_MAX-1:0]   req,
                                      input logic [RR_IDX_W-1:0] ptr,
                                      input int                  n);
    rr_res_t           res;
    logic [RR_IDX_W:0] j;
    res = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      j = {1'b0, ptr} + (RR_IDX_W+1)'(k);
      if (j >= (RR_IDX_W+1)'(n)) j = j - (RR_IDX_W+1)'(n);
      if (k < n && !res.found && req[j[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/maze_rr_pick.sv
// Cyclic find-first-set over N requesters, starting at a rotating pointer.
module maze_rr_pick
  import maze_pkg::*;
#(
  parameter  int N     = 14,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  rr_res_t res;

  always_comb res = rr_pick(RR_MAX'(req_i), RR_IDX_W'(ptr_i), N);

  assign found_o = res.found;
  assign idx_o   = res.idx[IDX_W-1:0];

endmodule

// File: rtl/maze_eject_arb.sv
// MAZE per-node ejection arbiter: QoS-then-round-robin selection among the
// 14 torus links into a single registered ejection stage, with starvation promotion.
module maze_eject_arb
  import maze_pkg::*;
#(
  parameter int PKT_W      = maze_pkg::PKT_W,
  parameter int N_IN       = maze_pkg::N_X_LINKS + maze_pkg::N_Y_LINKS,
  parameter int STARVE_LIM = 8,
  parameter int QOS_BIT    = maze_pkg::QOS_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       in_vld,
  output logic [N_IN-1:0]       in_rdy,
  input  logic [N_IN*PKT_W-1:0] in_pkt,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [PKT_W-1:0]      out_pkt,
  output logic [3:0]            out_src_idx,
  output logic                  starve_evt
);

  localparam int               IDX_W = $clog2(N_IN);
  localparam int               CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM   = CNT_W'(STARVE_LIM);

  logic                   out_vld_q, out_vld_d;
  logic [PKT_W-1:0]       out_pkt_q, out_pkt_d;
  logic [3:0]             out_src_q, out_src_d;
  logic                   starve_q,  starve_d;
  logic [IDX_W-1:0]       rr_hi_q,   rr_hi_d;
  logic [IDX_W-1:0]       rr_lo_q,   rr_lo_d;
  logic [CNT_W-1:0]       wcnt_q [N_IN];
  logic [CNT_W-1:0]       wcnt_d [N_IN];

  logic [N_IN-1:0]        qos, promo, hi_req, lo_req;
  logic                   hi_found, lo_found;
  logic [IDX_W-1:0]       hi_idx, lo_idx;
  logic                   accept, gnt_vld, gnt_hi, xfer;
  logic [IDX_W-1:0]       gnt_idx, gnt_nxt;

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    qos   = '0;
    promo = '0;
    for (int i = 0; i < N_IN; i++) begin
      qos[i]   = in_pkt[i*PKT_W + QOS_BIT];
      promo[i] = (wcnt_q[i] == LIM);
    end
  end

  // Promoted low-QoS inputs join native high-QoS traffic under rr_hi.
  assign hi_req = in_vld & (qos | promo);
  assign lo_req = in_vld & ~hi_req;

  maze_rr_pick #(.N(N_IN)) u_pick_hi (
    .req_i   (hi_req),
    .ptr_i   (rr_hi_q),
    .found_o (hi_found),
    .idx_o   (hi_idx)
  );

  maze_rr_pick #(.N(N_IN)) u_pick_lo (
    .req_i   (lo_req),
    .ptr_i   (rr_lo_q),
    .found_o (lo_found),
    .idx_o   (lo_idx)
  );

  // A draining output frees the stage in the same cycle: no bubble.
  always_comb begin
    accept  = ~out_vld_q | out_rdy;
    gnt_vld = hi_found | lo_found;
    gnt_hi  = hi_found;
    gnt_idx = hi_found ? hi_idx : lo_idx;
    gnt_nxt = (gnt_idx == IDX_W'(N_IN - 1)) ? '0 : gnt_idx + 1'b1;
    xfer    = accept & gnt_vld & ~rst;
    in_rdy  = '0;
    if (xfer) in_rdy[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_pkt_d = out_pkt_q;
    out_src_d = out_src_q;
    rr_hi_d   = rr_hi_q;
    rr_lo_d   = rr_lo_q;
    if (xfer) begin
      out_vld_d = 1'b1;
      out_pkt_d = in_pkt[gnt_idx*PKT_W +: PKT_W];
      out_src_d = 4'(gnt_idx);
      if (gnt_hi) rr_hi_d = gnt_nxt;
      else        rr_lo_d = gnt_nxt;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  // Waiting is wall-clock time, so counters also advance under backpressure.
  always_comb begin
    starve_d = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      wcnt_d[i] = wcnt_q[i];
      if (xfer && gnt_idx == IDX_W'(i)) begin
        wcnt_d[i] = '0;
      end else if (in_vld[i] && wcnt_q[i] < LIM) begin
        wcnt_d[i] = wcnt_q[i] + 1'b1;
        if (wcnt_q[i] == LIM - 1'b1) starve_d = 1'b1;
      end else if (!in_vld[i]) begin
        wcnt_d[i] = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_pkt_q <= '0;
      out_src_q <= '0;
      starve_q  <= 1'b0;
      rr_hi_q   <= '0;
      rr_lo_q   <= '0;
      // NOTE: the counter array is reset element by element because stale
      // counts would promote inputs straight out of reset.
      for (int i = 0; i < N_IN; i++) wcnt_q[i] <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_pkt_q <= out_pkt_d;
      out_src_q <= out_src_d;
      starve_q  <= starve_d;
      rr_hi_q   <= rr_hi_d;
      rr_lo_q   <= rr_lo_d;
      for (int i = 0; i < N_IN; i++) wcnt_q[i] <= wcnt_d[i];
    end
  end

  assign out_vld     = out_vld_q;
  assign out_pkt     = out_pkt_q;
  assign out_src_idx = out_src_q;
  assign starve_evt  = starve_q;

endmodule

// File: tb/tb_maze_eject_arb.sv
// Randomised and directed bench for maze_eject_arb against a queue-free
// behavioural model of the arbitration, output stage and wait counters.
module tb_maze_eject_arb;
  import maze_pkg::*;

  localparam int NI  = 14;
  localparam int PW  = 23;
  localparam int LIM = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NI-1:0]    in_vld;
  logic [NI-1:0]    in_rdy;
  logic [NI*PW-1:0] in_pkt;
  logic             out_vld;
  logic             out_rdy;
  logic [PW-1:0]    out_pkt;
  logic [3:0]       out_src_idx;
  logic             starve_evt;

  logic [PW-1:0]    pkt_a [NI];

  int n_checks = 0;
  int n_fail   = 0;

  bit            m_vld;
  logic [PW-1:0] m_pkt;
  int            m_src;
  bit            m_evt;
  int            m_wait [NI];
  int            m_rr_hi, m_rr_lo;
  int            m_last_g;

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < NI; i++) in_pkt[i*PW +: PW] = pkt_a[i];

  maze_eject_arb #(.STARVE_LIM(LIM)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .in_pkt      (in_pkt),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_pkt     (out_pkt),
    .out_src_idx (out_src_idx),
    .starve_evt  (starve_evt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_pkt = '0; m_src = 0; m_evt = 0;
    m_rr_hi = 0; m_rr_lo = 0; m_last_g = -1;
    for (int i = 0; i < NI; i++) m_wait[i] = 0;
  endtask

  function automatic logic [PW-1:0] mk_pkt(input int src, input bit q, input logic [7:0] d);
    pkt_t p;
    p.ptype = 2'd1; p.qos = q; p.src = 6'(src); p.tgt = 6'd9; p.data = d;
    return p;
  endfunction

  // One clock: compare at negedge, advance the model at the posedge.
  task automatic step();
    int            g, idx;
    bit            g_hi, acc, ordy, n_evt;
    logic [NI-1:0] exp_rdy;
    int            n_wait [NI];
    @(negedge clk);
    acc = !m_vld || out_rdy;
    g = -1; g_hi = 0;
    for (int k = 0; k < NI; k++) begin
      idx = (m_rr_hi + k) % NI;
      if (g < 0 && in_vld[idx] && (pkt_a[idx][20] || m_wait[idx] == LIM)) begin
        g = idx; g_hi = 1;
      end
    end
    for (int k = 0; k < NI; k++) begin
      idx = (m_rr_lo + k) % NI;
      if (g < 0 && in_vld[idx] && !(pkt_a[idx][20] || m_wait[idx] == LIM)) g = idx;
    end
    exp_rdy = '0;
    if (acc && g >= 0) exp_rdy[g] = 1'b1;
    check("in_rdy", 32'(in_rdy), 32'(exp_rdy));
    check("out_vld", 32'(out_vld), 32'(m_vld));
    check("out_pkt", 32'(out_pkt), 32'(m_pkt));
    check("out_src_idx", 32'(out_src_idx), m_src);
    check("starve_evt", 32'(starve_evt), 32'(m_evt));
    m_last_g = (acc && g >= 0) ? g : -1;
    ordy  = out_rdy;
    n_evt = 0;
    for (int i = 0; i < NI; i++) begin
      n_wait[i] = m_wait[i];
      if (i == m_last_g) n_wait[i] = 0;
      else if (in_vld[i] && m_wait[i] < LIM) begin
        n_wait[i] = m_wait[i] + 1;
        if (n_wait[i] == LIM) n_evt = 1;
      end else if (!in_vld[i]) n_wait[i] = 0;
    end
    @(posedge clk);
    if (m_last_g >= 0) begin
      m_vld = 1; m_pkt = pkt_a[m_last_g]; m_src = m_last_g;
      if (g_hi) m_rr_hi = (m_last_g + 1) % NI;
      else      m_rr_lo = (m_last_g + 1) % NI;
    end else if (ordy) m_vld = 0;
    for (int i = 0; i < NI; i++) m_wait[i] = n_wait[i];
    m_evt = n_evt;
    #1;
  endtask

  // Short asynchronous reset pulse placed mid-cycle, away from both edges.
  task automatic async_rst();
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_vld", 32'(out_vld), 0);
    check("rst_in_rdy", 32'(in_rdy), 0);
    check("rst_starve", 32'(starve_evt), 0);
    for (int i = 0; i < NI; i++) check("rst_wcnt", 32'(dut.wcnt_q[i]), 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drive(input logic [NI-1:0] v, input logic [NI-1:0] q);
    in_vld = v;
    for (int i = 0; i < NI; i++) pkt_a[i] = mk_pkt(i, q[i], 8'(i * 17));
  endtask

  initial begin
    rst = 1'b1;
    out_rdy = 1'b1;
    in_vld = '1;
    for (int i = 0; i < NI; i++) pkt_a[i] = 23'($urandom);
    #12;
    check("reset_in_rdy", 32'(in_rdy), 0);
    check("reset_out_vld", 32'(out_vld), 0);
    check("reset_out_pkt", 32'(out_pkt), 0);
    check("reset_out_src", 32'(out_src_idx), 0);
    check("reset_starve", 32'(starve_evt), 0);
    rst = 1'b0;
    model_reset();
    in_vld = '0;
    step();

    // Single requester.
    in_vld = 14'(1 << 3);
    pkt_a[3] = 23'h0A51C3;
    step();
    check("single_vld", 32'(out_vld), 1);
    check("single_pkt", 32'(out_pkt), 32'h0A51C3);
    check("single_src", 32'(out_src_idx), 3);
    in_vld = '0;
    step();

    // Round-robin among low-QoS inputs 2, 5, 9.
    drive(14'b00_0010_0010_0100, '0);
    for (int c = 0; c < 7; c++) step();

    // High QoS ahead of low QoS.
    drive('0, '0); step(); step();
    drive(14'b01_0000_0000_0010, 14'b01_0000_0000_0000);
    step();
    check("qos_first", 32'(out_src_idx), 12);
    in_vld[12] = 1'b0;
    step();
    check("qos_second", 32'(out_src_idx), 1);

    // Backpressure with a full output stage, then drain with no bubble.
    drive(14'b10_0100_1000_0001, 14'b00_0100_0000_0000);
    step();
    out_rdy = 1'b0;
    for (int c = 0; c < 5; c++) step();
    out_rdy = 1'b1;
    for (int c = 0; c < 4; c++) step();

    // Starvation: input 6 (low) against streaming high-QoS inputs 0 and 7.
    drive('0, '0); step();
    drive(14'b00_0000_1100_0001, 14'b00_0000_1000_0001);
    for (int c = 0; c < 4; c++) step();
    check("starve_wcnt6", 32'(dut.wcnt_q[6]), LIM);
    for (int c = 0; c < 6; c++) step();

    // Async reset while the output holds a packet, then a fresh grant.
    out_rdy = 1'b0;
    step();
    async_rst();
    out_rdy = 1'b1;
    drive(14'(1 << 4), '0);
    step();
    check("post_rst_src", 32'(out_src_idx), 4);
    step();

    // Randomised traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (i == m_last_g) begin
          in_vld[i] = ($urandom_range(0, 3) != 0);
          pkt_a[i]  = 23'($urandom);
        end else if (!in_vld[i]) begin
          in_vld[i] = ($urandom_range(0, 3) == 0);
          pkt_a[i]  = 23'($urandom);
        end else if ($urandom_range(0, 31) == 0) begin
          in_vld[i] = 1'b0;
        end
      end
      out_rdy = ($urandom_range(0, 3) != 0);
      if (c % 700 == 699) async_rst();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_eject_arb.md
Name: maze_eject_arb

Overview:
- Per-node ejection arbiter for the MAZE 8×8 torus network.
- Shares one local ejection port among the node's 14 incoming torus links: xi[0..6] map to inputs 0–6, yi[0..6] map to inputs 7–13.
- Arbitration order: QoS class first, then round-robin within the class. A per-input starvation counter promotes low-QoS traffic that has waited too long.
- The output is a single-entry registered stage that sits between the link buffers and the node's local sink.

Parameters:
- PKT_W, 23, packet width; fields are {type[22:21], qos[20], src[19:14], tgt[13:8], data[7:0]}.
- N_IN, 14, number of requesters (7 X-direction, 7 Y-direction).
- STARVE_LIM, 8, number of waiting cycles before a low-QoS input is promoted (legal range 1..255).
- QOS_BIT, 20, bit position of the qos field within the packet.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_vld  in  N_IN  per-input valid.
- in_rdy  out  N_IN  per-input ready; at most one bit is set per cycle (one-hot or zero).
- in_pkt  in  N_IN*PKT_W  packed payloads; input i occupies bits [i*PKT_W +: PKT_W].
- out_vld  out  1  ejection valid.
- out_rdy  in  1  ejection ready from the local sink.
- out_pkt  out  PKT_W  ejection payload.
- out_src_idx  out  4  index of the input that supplied out_pkt.
- starve_evt  out  1  one-cycle pulse when any input's counter reaches STARVE_LIM.

Behaviour:
- Reset (async, rst=1): out_vld=0, out_pkt=0, out_src_idx=0, starve_evt=0, rr_hi=0, rr_lo=0, all wait counters=0, in_rdy=0 (combinational, because out stage is empty and no valid is considered during reset).
- accept = ~out_vld | out_rdy. This gives full throughput: back-to-back transfers with no bubble.
- Eligibility:
  - promo[i] = (wcnt[i] == STARVE_LIM).
  - H = in_vld & (qos[i] | promo[i]).
  - L = in_vld & ~H.
- Grant selection:
  - If H != 0, grant the first set bit of H at or after rr_hi, cyclic over 0..N_IN-1.
  - Otherwise, grant the first set bit of L at or after rr_lo.
  - Otherwise, no grant.
- in_rdy[g] = accept & grant valid. in_rdy is combinational from in_vld, in_pkt qos bits, state and out_rdy; there is no combinational path from in_rdy to in_vld.
- Transfer on in_vld[g] & in_rdy[g]:
  - Next edge: out_pkt <= in_pkt[g], out_src_idx <= g, out_vld <= 1.
  - If the grant came from H, rr_hi <= (g+1) mod N_IN. If from L, rr_lo <= (g+1) mod N_IN. The other pointer is unchanged.
- Latency: exactly 1 cycle from the input handshake to out_vld.
- Output stage when no transfer:
  - out_vld <= 0 if out_rdy was 1.
  - out_vld, out_pkt and out_src_idx hold stable while out_vld=1 and out_rdy=0.
- Wait counters, per input i, each cycle, in priority order:
  1. Transfer on i: wcnt <= 0.
  2. Else, in_vld[i] & wcnt<STARVE_LIM: wcnt <= wcnt+1.
  3. Else, ~in_vld[i]: wcnt <= 0.
  4. Else: saturate (hold).
- Counter width is $clog2(STARVE_LIM+1).
- Counters advance during output backpressure (accept=0), because waiting is wall-clock.
- starve_evt is registered: it is 1 in the cycle after any wcnt transitions STARVE_LIM-1 → STARVE_LIM. Simultaneous transitions produce a single pulse.
- Promoted inputs compete inside H under rr_hi ordering, alongside native high-QoS inputs.
- Wrap-around: the pointer advances from N_IN-1 to 0. A pointer equal to the granted index +1 that wraps is legal.
- Reset asserted mid-transfer: the output packet is dropped and out_vld drops immediately (async). Upstream link buffers retain their data because in_rdy=0 during reset.
- in_vld deasserted by upstream without a handshake is legal (link buffers never do this). The counter then clears.

Decomposition:
- Shared package maze_pkg:
  - PKT_W, field offsets (TYPE_MSB/LSB, QOS_BIT, SRC_MSB/LSB, TGT_MSB/LSB, DATA_MSB/LSB).
  - N_X_LINKS=7, N_Y_LINKS=7.
  - Function rr_pick(req, ptr) returning {found, idx}.
- One sub-module is natural: maze_rr_pick, a parameterised cyclic find-first-set from a pointer. It is instantiated twice, once for H and once for L.
- Counters and the output register stay in the top module.

Test Plan:
- Single requester: in_vld[3]=1 with pkt 23'h0A5_1C3, out_rdy=1 → in_rdy[3]=1 in the same cycle; out_vld=1, out_pkt=23'h0A5_1C3 and out_src_idx=3 the next cycle.
- Round-robin: inputs 2, 5 and 9 held valid with qos=0 and out_rdy=1 → grant order 2, 5, 9, 2, 5, … one per cycle. rr_lo ends at 3 after the first grant.
- QoS priority: input 1 (qos=0) and input 12 (qos=1) both valid → 12 is granted first and 1 the next cycle. rr_hi=13 and rr_lo=2 afterwards.
- Backpressure: out_rdy=0 for 5 cycles with the output full → out_pkt and out_src_idx are stable and in_rdy is all zero. out_rdy=1 → the held packet drains and the next grant is taken in the same cycle with no bubble.
- Starvation, with STARVE_LIM=4: input 6 (qos=0) waits while inputs 0 and 7 (qos=1) stream continuously → wcnt[6] reaches 4 after 4 cycles and starve_evt pulses once. Input 6 is granted within 2 further grants under rr_hi ordering, and wcnt[6] returns to 0.
- Async reset: rst pulses for 1 ns mid-cycle while out_vld=1 → out_vld=0 and all counters are 0 immediately. After release, in_vld[4]=1 → it is granted with rr_lo=0.
